// File: rtl/store_buffer_fwd_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_fwd_pkg
//   Shared constants for the store buffer and its forwarding selector.
//   SB_DEPTH    default number of buffered stores (power of 2, >= 2)
//   SB_AW/SB_DW default byte-address and data widths
//   WORD_OFFSET number of byte-offset bits below the word address
//   BYTE_W      bits per byte lane
//   mask_width  byte-enable mask width for a given data width
// -----------------------------------------------------------------------------
package store_buffer_fwd_pkg;

   localparam int SB_DEPTH    = 4;
   localparam int SB_AW       = 32;
   localparam int SB_DW       = 32;
   localparam int WORD_OFFSET = 2;
   localparam int BYTE_W      = 8;

   function automatic int mask_width(input int dw);
      return dw / BYTE_W;
   endfunction

endpackage : store_buffer_fwd_pkg

// File: rtl/store_buffer_fwd_fwd_match.sv
// -----------------------------------------------------------------------------
// stb_fwd_match
//   Combinational store-to-load forwarding selector. For every byte lane it
//   picks the youngest valid entry whose word address equals the load word
//   address and whose byte enable is set for that lane.
//
//   ld_valid   in   load present; when low no lane is forwarded
//   ld_word    in   load word address (byte offset already stripped)
//   head       in   index of the oldest entry
//   ent_valid  in   per-entry valid vector
//   ent_word   in   per-entry word address
//   ent_data   in   per-entry lane-aligned data
//   ent_mask   in   per-entry byte-enable mask
//   fwd_mask   out  lanes supplied by the buffer
//   fwd_data   out  merged forwarded bytes (zero where fwd_mask is 0)
// -----------------------------------------------------------------------------
module stb_fwd_match
   import store_buffer_fwd_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
) (
   input  logic                                        ld_valid,
   input  logic [AW-WORD_OFFSET-1:0]                   ld_word,
   input  logic [$clog2(DEPTH)-1:0]                    head,
   input  logic [DEPTH-1:0]                            ent_valid,
   input  logic [DEPTH-1:0][AW-WORD_OFFSET-1:0]        ent_word,
   input  logic [DEPTH-1:0][DW-1:0]                    ent_data,
   input  logic [DEPTH-1:0][mask_width(DW)-1:0]        ent_mask,
   output logic [mask_width(DW)-1:0]                   fwd_mask,
   output logic [DW-1:0]                               fwd_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int MW = mask_width(DW);

   logic [PW-1:0] idx;

   // Walk entries from oldest (age 0) to youngest; a later hit overwrites an
   // earlier one, so each lane ends up holding the youngest matching byte.
   always_comb begin
      // NOTE: every output gets a default before any conditional write, so no
      // path leaves a variable unassigned and no latch is inferred.
      fwd_mask = '0;
      fwd_data = '0;
      idx      = '0;
      for (int age = 0; age < DEPTH; age++) begin
         // NOTE: blocking assignments here are deliberate: each iteration must
         // see the lanes written by older entries so that it can override them.
         idx = head + PW'(age);   // wraps modulo DEPTH (power of 2)
         if (ld_valid && ent_valid[idx] && (ent_word[idx] == ld_word)) begin
            for (int b = 0; b < MW; b++) begin
               if (ent_mask[idx][b]) begin
                  fwd_mask[b]                   = 1'b1;
                  fwd_data[b*BYTE_W +: BYTE_W] = ent_data[idx][b*BYTE_W +: BYTE_W];
               end
            end
         end
      end
   end

endmodule : stb_fwd_match

// File: rtl/store_buffer_fwd.sv
// -----------------------------------------------------------------------------
// store_buffer_fwd
//   Store buffer between the X stage and the DMEM write port. Stores are
//   queued in a circular FIFO and written out whenever DMEM is free; loads in
//   X receive any queued bytes for their word (youngest store wins per byte).
//
//   clk          in   pipeline clock
//   rst          in   synchronous, active-high reset (discards pending stores)
//   st_valid     in   store in X
//   st_addr      in   store byte address (bits [1:0] ignored)
//   st_data      in   lane-aligned store data
//   st_wmask     in   byte-enable mask
//   st_ready     out  buffer can accept a store this cycle
//   ld_valid     in   load in X
//   ld_addr      in   load byte address (word compare)
//   ld_fwd_mask  out  lanes supplied by the buffer
//   ld_fwd_data  out  forwarded bytes
//   mem_wr_valid out  head entry presented to DMEM
//   mem_wr_addr  out  head word address, [1:0] = 0
//   mem_wr_data  out  head data
//   mem_wr_mask  out  head mask
//   mem_wr_ready in   DMEM write port free this cycle
//   empty        out  no pending stores
//   count        out  occupancy
// -----------------------------------------------------------------------------
module store_buffer_fwd
   import store_buffer_fwd_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        st_valid,
   input  logic [AW-1:0]               st_addr,
   input  logic [DW-1:0]               st_data,
   input  logic [mask_width(DW)-1:0]   st_wmask,
   output logic                        st_ready,
   input  logic                        ld_valid,
   input  logic [AW-1:0]               ld_addr,
   output logic [mask_width(DW)-1:0]   ld_fwd_mask,
   output logic [DW-1:0]               ld_fwd_data,
   output logic                        mem_wr_valid,
   output logic [AW-1:0]               mem_wr_addr,
   output logic [DW-1:0]               mem_wr_data,
   output logic [mask_width(DW)-1:0]   mem_wr_mask,
   input  logic                        mem_wr_ready,
   output logic                        empty,
   output logic [$clog2(DEPTH):0]      count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int MW = mask_width(DW);
   localparam int WW = AW - WORD_OFFSET;

   // ---------------------------------------------------------------------------
   // Storage and pointers
   // ---------------------------------------------------------------------------
   logic [PW-1:0]                head;
   logic [PW-1:0]                tail;
   logic [CW-1:0]                count_q;
   logic [CW-1:0]                count_d;
   logic [DEPTH-1:0]             ent_valid;
   logic [DEPTH-1:0][WW-1:0]     ent_word;
   logic [DEPTH-1:0][DW-1:0]     ent_data;
   logic [DEPTH-1:0][MW-1:0]     ent_mask;

   logic enq;
   logic deq;

   // Byte-offset bits never take part in matching or in the DMEM address.
   logic unused_offset_bits;
   assign unused_offset_bits = ^{st_addr[WORD_OFFSET-1:0], ld_addr[WORD_OFFSET-1:0]};

   // ---------------------------------------------------------------------------
   // Handshakes: both flags come from registered occupancy only, so a full
   // buffer that drains this cycle still refuses the store until next cycle,
   // and a store enqueued this cycle cannot drain before the next one.
   // ---------------------------------------------------------------------------
   assign st_ready     = (count_q != CW'(DEPTH));
   assign mem_wr_valid = (count_q != '0);
   assign empty        = (count_q == '0);
   assign count        = count_q;

   assign enq = st_valid & st_ready;
   assign deq = mem_wr_valid & mem_wr_ready;

   always_comb begin
      count_d = count_q;
      unique case ({enq, deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Control state. Enqueue and dequeue never touch the same slot in one cycle:
   // head == tail only when empty (no dequeue) or full (no enqueue).
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all sequential state so every
      // register samples the pre-edge values, independent of statement order.
      if (rst) begin
         head      <= '0;
         tail      <= '0;
         count_q   <= '0;
         ent_valid <= '0;
      end else begin
         if (enq) begin
            ent_valid[tail] <= 1'b1;
            tail            <= tail + PW'(1);
         end
         if (deq) begin
            ent_valid[head] <= 1'b0;
            head            <= head + PW'(1);
         end
         count_q <= count_d;
      end
   end

   // NOTE: the entry payload is deliberately not reset; it is only ever read
   // through ent_valid / count_q, which are reset, so stale contents are inert.
   always_ff @(posedge clk) begin
      if (enq) begin
         ent_word[tail] <= st_addr[AW-1:WORD_OFFSET];
         ent_data[tail] <= st_data;
         ent_mask[tail] <= st_wmask;
      end
   end

   // ---------------------------------------------------------------------------
   // DMEM write port: straight from the head entry, stable until accepted.
   // A zero mask is still presented and drained as a no-op write.
   // ---------------------------------------------------------------------------
   assign mem_wr_addr = {ent_word[head], {WORD_OFFSET{1'b0}}};
   assign mem_wr_data = ent_data[head];
   assign mem_wr_mask = ent_mask[head];

   // ---------------------------------------------------------------------------
   // Forwarding from registered entries only; the head entry being drained
   // this cycle is still valid here, and a store entering this cycle is not.
   // ---------------------------------------------------------------------------
   stb_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fwd_match (
      .ld_valid  (ld_valid),
      .ld_word   (ld_addr[AW-1:WORD_OFFSET]),
      .head      (head),
      .ent_valid (ent_valid),
      .ent_word  (ent_word),
      .ent_data  (ent_data),
      .ent_mask  (ent_mask),
      .fwd_mask  (ld_fwd_mask),
      .fwd_data  (ld_fwd_data)
   );

endmodule : store_buffer_fwd

// File: tb/tb_store_buffer_fwd.sv
// -----------------------------------------------------------------------------
// tb_store_buffer_fwd
//   Self-checking bench for store_buffer_fwd. The reference model is a queue
//   of pending stores in program order: the front is what DMEM must see next,
//   and forwarding is recomputed by scanning the queue oldest to youngest.
// -----------------------------------------------------------------------------
module tb_store_buffer_fwd;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int MW    = DW / 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             st_valid;
   logic [AW-1:0]    st_addr;
   logic [DW-1:0]    st_data;
   logic [MW-1:0]    st_wmask;
   logic             st_ready;
   logic             ld_valid;
   logic [AW-1:0]    ld_addr;
   logic [MW-1:0]    ld_fwd_mask;
   logic [DW-1:0]    ld_fwd_data;
   logic             mem_wr_valid;
   logic [AW-1:0]    mem_wr_addr;
   logic [DW-1:0]    mem_wr_data;
   logic [MW-1:0]    mem_wr_mask;
   logic             mem_wr_ready;
   logic             empty;
   logic [2:0]       count;

   always #5 clk = ~clk;

   store_buffer_fwd #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .st_valid     (st_valid),
      .st_addr      (st_addr),
      .st_data      (st_data),
      .st_wmask     (st_wmask),
      .st_ready     (st_ready),
      .ld_valid     (ld_valid),
      .ld_addr      (ld_addr),
      .ld_fwd_mask  (ld_fwd_mask),
      .ld_fwd_data  (ld_fwd_data),
      .mem_wr_valid (mem_wr_valid),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .mem_wr_mask  (mem_wr_mask),
      .mem_wr_ready (mem_wr_ready),
      .empty        (empty),
      .count        (count)
   );

   typedef struct {
      logic [AW-1:0] addr;   // word-aligned
      logic [DW-1:0] data;
      logic [MW-1:0] mask;
   } store_t;

   store_t q[$];              // pending stores, oldest first
   int     vectors     = 0;
   int     miscompares = 0;
   int     accepted    = 0;   // stores the model says were accepted
   int     dut_writes  = 0;   // DMEM handshakes observed on the DUT

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                        input logic [MW-1:0] sm, input logic lv, input logic [AW-1:0] la,
                        input logic rdy);
      st_valid     = sv;
      st_addr      = sa;
      st_data      = sd;
      st_wmask     = sm;
      ld_valid     = lv;
      ld_addr      = la;
      mem_wr_ready = rdy;
   endtask

   // Let combinational outputs settle mid-cycle, then compare against the model.
   task automatic sample();
      logic [MW-1:0] em;
      logic [DW-1:0] ed;
      logic [DW-1:0] lanes;
      #2;
      check("st_ready",     st_ready,     q.size() != DEPTH);
      check("mem_wr_valid", mem_wr_valid, q.size() != 0);
      check("empty",        empty,        q.size() == 0);
      check("count",        count,        q.size());
      if (q.size() != 0) begin
         check("mem_wr_addr", mem_wr_addr, q[0].addr);
         check("mem_wr_data", mem_wr_data, q[0].data);
         check("mem_wr_mask", mem_wr_mask, q[0].mask);
      end
      em = '0;
      ed = '0;
      if (ld_valid) begin
         foreach (q[i]) begin
            if (q[i].addr[AW-1:2] == ld_addr[AW-1:2]) begin
               for (int b = 0; b < MW; b++) begin
                  if (q[i].mask[b]) begin
                     em[b]        = 1'b1;
                     ed[8*b +: 8] = q[i].data[8*b +: 8];
                  end
               end
            end
         end
      end
      lanes = '0;
      for (int b = 0; b < MW; b++) lanes[8*b +: 8] = {8{em[b]}};
      check("ld_fwd_mask", ld_fwd_mask, em);
      check("ld_fwd_data", ld_fwd_data & lanes, ed);
   endtask

   // Advance one clock and apply the FIFO rules to the model.
   task automatic tick();
      logic   acc;
      logic   dq;
      logic   hs;
      store_t e;
      acc    = st_valid && (q.size() != DEPTH);
      dq     = mem_wr_ready && (q.size() != 0);
      hs     = mem_wr_valid && mem_wr_ready && !rst;
      e.addr = {st_addr[AW-1:2], 2'b00};
      e.data = st_data;
      e.mask = st_wmask;
      @(posedge clk);
      if (rst) begin
         q.delete();
      end else begin
         if (hs) dut_writes++;
         if (dq) void'(q.pop_front());
         if (acc) begin
            q.push_back(e);
            accepted++;
         end
      end
      #1;
   endtask

   task automatic step(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       input logic [MW-1:0] sm, input logic lv, input logic [AW-1:0] la,
                       input logic rdy);
      drive(sv, sa, sd, sm, lv, la, rdy);
      sample();
      tick();
   endtask

   task automatic do_reset();
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      logic [AW-1:0] held_addr;
      logic [DW-1:0] held_data;
      int            issued;
      int            r;
      logic          sv, lv;

      rst = 1'b1;
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
      tick();
      do_reset();

      // 1. idle after reset, load present
      drive(1'b0, '0, '0, '0, 1'b1, 32'h100, 1'b0);
      sample();
      check("t1_st_ready", st_ready, 1'b1);
      check("t1_empty", empty, 1'b1);
      check("t1_mem_wr_valid", mem_wr_valid, 1'b0);
      check("t1_count", count, 3'd0);
      check("t1_fwd_mask", ld_fwd_mask, 4'h0);
      tick();

      // 2. word store, forwarded to a later load, then drained once
      step(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b0, '0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 32'h102, 1'b0);
      sample();
      check("t2_fwd_mask", ld_fwd_mask, 4'hF);
      check("t2_fwd_data", ld_fwd_data, 32'hDEAD_BEEF);
      tick();
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
      sample();
      check("t2_wr_addr", mem_wr_addr, 32'h100);
      check("t2_wr_mask", mem_wr_mask, 4'hF);
      tick();
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
      sample();
      check("t2_empty", empty, 1'b1);
      tick();

      // 3. youngest byte wins
      step(1'b1, 32'h200, 32'h0000_0011, 4'b0001, 1'b0, '0, 1'b0);
      step(1'b1, 32'h200, 32'h0000_0022, 4'b0001, 1'b0, '0, 1'b0);
      step(1'b1, 32'h202, 32'h3344_0000, 4'b1100, 1'b0, '0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 32'h200, 1'b0);
      sample();
      check("t3_fwd_mask", ld_fwd_mask, 4'hD);
      check("t3_fwd_data", ld_fwd_data & 32'hFFFF_00FF, 32'h3344_0022);
      tick();
      while (q.size() != 0 && vectors < 5000) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);

      // 4. fill, stall the fifth store, drain one, then accept it
      for (int i = 0; i < 4; i++)
         step(1'b1, 32'h500 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 1'b0, '0, 1'b0);
      drive(1'b1, 32'h510, 32'hA000_0004, 4'hF, 1'b0, '0, 1'b0);
      sample();
      check("t4_st_ready", st_ready, 1'b0);
      check("t4_count", count, 3'd4);
      tick();
      step(1'b1, 32'h510, 32'hA000_0004, 4'hF, 1'b0, '0, 1'b1);  // drains, still refuses
      drive(1'b1, 32'h510, 32'hA000_0004, 4'hF, 1'b1, 32'h510, 1'b0);
      sample();
      check("t4_accept_after_drain", st_ready, 1'b1);
      tick();
      step(1'b0, '0, '0, '0, 1'b1, 32'h510, 1'b0);               // wrapped entry forwards
      for (int i = 0; i < 6; i++) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);

      // 5. full buffer under continuous drain and store pressure
      for (int i = 0; i < 4; i++)
         step(1'b1, 32'h600 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF, 1'b0, '0, 1'b0);
      issued = 0;
      for (int cyc = 0; cyc < 40 && issued < 8; cyc++) begin
         held_addr = 32'h700 + 32'(4 * issued);
         held_data = 32'hC000_0000 + 32'(issued);
         drive(1'b1, held_addr, held_data, 4'hF, 1'b0, '0, 1'b1);
         sample();
         if (q.size() != DEPTH) issued++;
         tick();
      end
      check("t5_all_issued", issued, 8);
      for (int i = 0; i < 6; i++) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);

      // 6. reset with stores pending discards them
      step(1'b1, 32'h800, 32'h1111_1111, 4'hF, 1'b0, '0, 1'b0);
      step(1'b1, 32'h804, 32'h2222_2222, 4'hF, 1'b0, '0, 1'b0);
      step(1'b1, 32'h808, 32'h3333_3333, 4'hF, 1'b0, '0, 1'b0);
      accepted -= 3;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, '0, '0, 1'b1, 32'h800 + 32'(4 * i), 1'b1);
         sample();
         check("t6_fwd_mask", ld_fwd_mask, 4'h0);
         check("t6_no_write", mem_wr_valid, 1'b0);
         tick();
      end

      // 7. randomized traffic on a small address pool
      for (int i = 0; i < 400; i++) begin
         if (i == 250) begin
            accepted -= q.size();
            do_reset();
         end
         r  = $urandom_range(0, 19);
         sv = (r < 8) || (r == 19);
         lv = (r >= 8);
         drive(sv, 32'h300 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)),
               $urandom, MW'($urandom_range(0, 15)), lv,
               32'h300 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)),
               $urandom_range(0, 2) != 0);
         sample();
         tick();
      end

      // Drain what is left and confirm every accepted store reached DMEM once.
      for (int i = 0; i < 20 && q.size() != 0; i++) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
      sample();
      check("final_empty", empty, 1'b1);
      check("writes_vs_accepted", dut_writes, accepted);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_store_buffer_fwd
